// File: rtl/time_set_pkg.sv
// Shared types and constants for the time-setting editor.
package time_set_pkg;

  // Editor states, walked in order IDLE -> ED_HR -> ED_MIN -> ED_SEC -> COMMIT.
  typedef enum logic [2:0] {
    IDLE,
    ED_HR,
    ED_MIN,
    ED_SEC,
    COMMIT
  } state_t;

  // Codes on field_sel telling the display mux which field to highlight.
  localparam logic [1:0] FS_NONE = 2'd0;
  localparam logic [1:0] FS_HR   = 2'd1;
  localparam logic [1:0] FS_MIN  = 2'd2;
  localparam logic [1:0] FS_SEC  = 2'd3;

  // Largest legal two-digit BCD value per field.
  localparam logic [7:0] HR_MAX = 8'h23;
  localparam logic [7:0] MS_MAX = 8'h59;

  // True in any of the three field-editing states.
  function automatic logic is_edit(input state_t s);
    return (s == ED_HR) || (s == ED_MIN) || (s == ED_SEC);
  endfunction

endpackage

// File: rtl/time_set_ctrl_bcd2_updown.sv
// Two-digit BCD up/down stepper with wrap at max_val and forced 00 when the
// present value is outside 00..max_val. Purely combinational.
module bcd2_updown (
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic [7:0] max_val,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] next_tens,
  output logic [3:0] next_ones
);

  logic in_range;

  // Digits are valid BCD, so the packed byte compares like the decimal value.
  assign in_range = (tens <= 4'd9) && (ones <= 4'd9) && ({tens, ones} <= max_val);

  // Step the value once; inc and dec together cancel out.
  always_comb begin
    // NOTE: every output gets a default first so no path through the
    // branches below can leave one unassigned and infer a latch.
    next_tens = tens;
    next_ones = ones;
    if (inc ^ dec) begin
      if (!in_range) begin
        next_tens = 4'd0;
        next_ones = 4'd0;
      end else if (inc) begin
        if ({tens, ones} == max_val) begin
          next_tens = 4'd0;
          next_ones = 4'd0;
        end else if (ones == 4'd9) begin
          next_tens = tens + 4'd1;
          next_ones = 4'd0;
        end else begin
          next_ones = ones + 4'd1;
        end
      end else begin
        if ({tens, ones} == 8'h00) begin
          next_tens = max_val[7:4];
          next_ones = max_val[3:0];
        end else if (ones == 4'd0) begin
          next_tens = tens - 4'd1;
          next_ones = 4'd9;
        end else begin
          next_ones = ones - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven time-setting editor: snapshots the live time, lets the user
// step hours/minutes/seconds with inc/dec, then issues a one-cycle commit.
// Optional feature: define TIME_SET_TIMEOUT_EN to abandon an idle edit after
// TIMEOUT_CYCLES cycles without any button activity.
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter logic [29:0] TIMEOUT_CYCLES = 30'd500_000_000,
  parameter int          BLINK_DIV      = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [3:0] cur_ht,
  input  logic [3:0] cur_ho,
  input  logic [3:0] cur_mt,
  input  logic [3:0] cur_mo,
  input  logic [3:0] cur_st,
  input  logic [3:0] cur_so,
  output logic [3:0] set_ht,
  output logic [3:0] set_ho,
  output logic [3:0] set_mt,
  output logic [3:0] set_mo,
  output logic [3:0] set_st,
  output logic [3:0] set_so,
  output logic [1:0] field_sel,
  output logic       editing,
  output logic       blink,
  output logic       commit
);

  state_t state, state_next;

  logic [3:0] hr_t, hr_o, mn_t, mn_o, sc_t, sc_o;
  logic       step_req;
  logic       enter_edit;
  logic       timeout;
  logic [BLINK_DIV:0] blink_cnt;

  // Mode has priority over inc/dec; a lone inc or dec asks for a field step.
  assign step_req   = (btn_inc ^ btn_dec) & ~btn_mode;
  assign enter_edit = (state == IDLE) & btn_mode;

  bcd2_updown u_hr (
    .tens(set_ht), .ones(set_ho), .max_val(HR_MAX),
    .inc(btn_inc), .dec(btn_dec), .next_tens(hr_t), .next_ones(hr_o)
  );

  bcd2_updown u_min (
    .tens(set_mt), .ones(set_mo), .max_val(MS_MAX),
    .inc(btn_inc), .dec(btn_dec), .next_tens(mn_t), .next_ones(mn_o)
  );

  bcd2_updown u_sec (
    .tens(set_st), .ones(set_so), .max_val(MS_MAX),
    .inc(btn_inc), .dec(btn_dec), .next_tens(sc_t), .next_ones(sc_o)
  );

`ifdef TIME_SET_TIMEOUT_EN
  logic [29:0] tmo_cnt;
  logic        any_btn;

  assign any_btn = btn_mode | btn_inc | btn_dec;
  // The counter is 0 in the first edit cycle, so hitting TIMEOUT_CYCLES-1
  // means the field has sat untouched for TIMEOUT_CYCLES cycles.
  assign timeout = is_edit(state) && !any_btn && (tmo_cnt == TIMEOUT_CYCLES - 30'd1);

  // Inactivity counter: restarts on any press or state change, saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (any_btn || (state_next != state)) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != '1) begin
      tmo_cnt <= tmo_cnt + 30'd1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_next = state;
    field_sel  = FS_NONE;
    editing    = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (btn_mode) state_next = ED_HR;
      end
      ED_HR: begin
        field_sel = FS_HR;
        editing   = 1'b1;
        if (btn_mode)     state_next = ED_MIN;
        else if (timeout) state_next = IDLE;
      end
      ED_MIN: begin
        field_sel = FS_MIN;
        editing   = 1'b1;
        if (btn_mode)     state_next = ED_SEC;
        else if (timeout) state_next = IDLE;
      end
      ED_SEC: begin
        field_sel = FS_SEC;
        editing   = 1'b1;
        if (btn_mode)     state_next = COMMIT;
        else if (timeout) state_next = IDLE;
      end
      COMMIT: begin
        commit     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Edit buffer: snapshot on entry, then step only the field being edited.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: these are six small registers, not a memory, so they take the
    // async reset; a reset mid-edit must leave the buffer cleared.
    if (!rst_n) begin
      {set_ht, set_ho, set_mt, set_mo, set_st, set_so} <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (btn_mode) begin
            {set_ht, set_ho} <= {cur_ht, cur_ho};
            {set_mt, set_mo} <= {cur_mt, cur_mo};
            {set_st, set_so} <= {cur_st, cur_so};
          end
        end
        ED_HR:   if (step_req) {set_ht, set_ho} <= {hr_t, hr_o};
        ED_MIN:  if (step_req) {set_mt, set_mo} <= {mn_t, mn_o};
        ED_SEC:  if (step_req) {set_st, set_so} <= {sc_t, sc_o};
        default: ;
      endcase
    end
  end

  // Free-running blink counter, restarted on entry so blink phase is fixed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          blink_cnt <= '0;
    else if (enter_edit) blink_cnt <= '0;
    else                 blink_cnt <= blink_cnt + 1'b1;
  end

  assign blink = editing & blink_cnt[BLINK_DIV];

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: directed table, hand-written corner
// sequences and a randomized run against a decimal-arithmetic reference model.
module tb_time_set_ctrl;

  localparam int TO           = 20;
  localparam int BD           = 3;
  localparam int BLINK_PERIOD = 1 << (BD + 1);
`ifdef TIME_SET_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk, rst_n;
  logic       btn_mode, btn_inc, btn_dec;
  logic [3:0] cur_ht, cur_ho, cur_mt, cur_mo, cur_st, cur_so;
  logic [3:0] set_ht, set_ho, set_mt, set_mo, set_st, set_so;
  logic [1:0] field_sel;
  logic       editing, blink, commit;

  int n_vec = 0;
  int n_bad = 0;

  time_set_ctrl #(.TIMEOUT_CYCLES(30'(TO)), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .cur_ht(cur_ht), .cur_ho(cur_ho), .cur_mt(cur_mt),
    .cur_mo(cur_mo), .cur_st(cur_st), .cur_so(cur_so),
    .set_ht(set_ht), .set_ho(set_ho), .set_mt(set_mt),
    .set_mo(set_mo), .set_st(set_st), .set_so(set_so),
    .field_sel(field_sel), .editing(editing), .blink(blink), .commit(commit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: md 0 = idle, 1..3 = editing field md, 4 = commit.
  int md;
  int ft[3];
  int fo[3];
  int bk;
  int q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    md = 0;
    bk = 0;
    q  = 0;
    for (int k = 0; k < 3; k++) begin
      ft[k] = 0;
      fo[k] = 0;
    end
  endtask

  task automatic field_step(input int f, input bit up);
    int mx, t, o, v;
    mx = (f == 0) ? 23 : 59;
    t  = ft[f];
    o  = fo[f];
    if (t > 9 || o > 9 || t * 10 + o > mx) v = 0;
    else if (up) v = (t * 10 + o + 1) % (mx + 1);
    else         v = (t * 10 + o + mx) % (mx + 1);
    ft[f] = v / 10;
    fo[f] = v % 10;
  endtask

  task automatic model_step(input bit m, input bit i, input bit d);
    int prev;
    prev = md;
    bk = (bk + 1) % BLINK_PERIOD;
    case (md)
      0: if (m) begin
        ft[0] = int'(cur_ht); fo[0] = int'(cur_ho);
        ft[1] = int'(cur_mt); fo[1] = int'(cur_mo);
        ft[2] = int'(cur_st); fo[2] = int'(cur_so);
        md = 1;
        bk = 0;
      end
      1, 2, 3: begin
        if (m) md = md + 1;
        else if (TMO_EN && !i && !d && q == TO - 1) md = 0;
        else if (i != d) field_step(md - 1, i);
      end
      default: md = 0;
    endcase
    if (m || i || d || md != prev) q = 0;
    else q++;
  endtask

  task automatic check_model();
    logic [23:0] e;
    bit ed;
    e  = {4'(ft[0]), 4'(fo[0]), 4'(ft[1]), 4'(fo[1]), 4'(ft[2]), 4'(fo[2])};
    ed = (md >= 1 && md <= 3);
    check("model_set", {set_ht, set_ho, set_mt, set_mo, set_st, set_so}, e);
    check("model_field_sel", field_sel, ed ? md : 0);
    check("model_editing", editing, ed);
    check("model_blink", blink, ed && (bk >= BLINK_PERIOD / 2));
    check("model_commit", commit, md == 4);
  endtask

  // Called on a falling edge: drive one cycle of buttons, advance, check.
  task automatic tick(input bit m, input bit i, input bit d);
    btn_mode = m;
    btn_inc  = i;
    btn_dec  = d;
    @(posedge clk);
    model_step(m, i, d);
    @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    btn_dec  = 1'b0;
    check_model();
  endtask

  task automatic set_cur(input logic [23:0] t);
    {cur_ht, cur_ho, cur_mt, cur_mo, cur_st, cur_so} = t;
  endtask

  typedef struct {
    bit          m, i, d;
    logic [23:0] set;
    logic [1:0]  fs;
    bit          ed, cm;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int n;
    tbl[0]  = '{1, 0, 0, 24'h123456, 2'd1, 1, 0};
    tbl[1]  = '{0, 1, 0, 24'h133456, 2'd1, 1, 0};
    tbl[2]  = '{1, 0, 0, 24'h133456, 2'd2, 1, 0};
    tbl[3]  = '{0, 0, 1, 24'h133356, 2'd2, 1, 0};
    tbl[4]  = '{0, 1, 0, 24'h133456, 2'd2, 1, 0};
    tbl[5]  = '{0, 1, 1, 24'h133456, 2'd2, 1, 0};
    tbl[6]  = '{1, 1, 0, 24'h133456, 2'd3, 1, 0};
    tbl[7]  = '{0, 0, 1, 24'h133455, 2'd3, 1, 0};
    tbl[8]  = '{0, 1, 0, 24'h133456, 2'd3, 1, 0};
    tbl[9]  = '{1, 0, 0, 24'h133456, 2'd0, 0, 1};
    tbl[10] = '{0, 0, 0, 24'h133456, 2'd0, 0, 0};
    tbl[11] = '{0, 1, 0, 24'h133456, 2'd0, 0, 0};

    rst_n = 1'b0;
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    set_cur(24'h123456);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_set", {set_ht, set_ho, set_mt, set_mo, set_st, set_so}, 24'h0);
    check("reset_field_sel", field_sel, 2'd0);
    check("reset_editing", editing, 1'b0);
    check("reset_blink", blink, 1'b0);
    check("reset_commit", commit, 1'b0);
    rst_n = 1'b1;

    // Directed table: snapshot, per-field edits, simultaneous buttons, commit.
    for (int k = 0; k < 12; k++) begin
      tick(tbl[k].m, tbl[k].i, tbl[k].d);
      check($sformatf("tbl%0d_set", k), {set_ht, set_ho, set_mt, set_mo, set_st, set_so}, tbl[k].set);
      check($sformatf("tbl%0d_fs", k), field_sel, tbl[k].fs);
      check($sformatf("tbl%0d_ed", k), editing, tbl[k].ed);
      check($sformatf("tbl%0d_commit", k), commit, tbl[k].cm);
    end

    // Hours wrap both ways at 23/00.
    set_cur(24'h230000);
    tick(1, 0, 0);
    check("hr_snap_23", {set_ht, set_ho}, 8'h23);
    tick(0, 1, 0);
    check("hr_inc_wrap", {set_ht, set_ho}, 8'h00);
    tick(0, 0, 1);
    check("hr_dec_wrap", {set_ht, set_ho}, 8'h23);
    repeat (3) tick(1, 0, 0);
    tick(0, 0, 0);

    // Ten increments from 09 cross the ones carry and land on 19.
    set_cur(24'h090000);
    tick(1, 0, 0);
    for (int k = 0; k < 10; k++) tick(0, 1, 0);
    check("hr_ten_incs", {set_ht, set_ho}, 8'h19);

    // Minutes borrow-wrap, inc+dec cancel, mode beats inc.
    tick(1, 0, 0);
    tick(0, 0, 1);
    check("min_dec_wrap", {set_mt, set_mo}, 8'h59);
    tick(0, 1, 1);
    check("min_inc_dec", {set_mt, set_mo}, 8'h59);
    tick(1, 1, 0);
    check("mode_inc_fs", field_sel, 2'd3);
    check("mode_inc_min", {set_mt, set_mo}, 8'h59);
    tick(0, 0, 1);
    check("sec_dec_wrap", {set_st, set_so}, 8'h59);
    tick(0, 1, 0);
    check("sec_inc_wrap", {set_st, set_so}, 8'h00);

    // Asynchronous reset while editing seconds: everything clears at once.
    rst_n = 1'b0;
    #1;
    check("rst_mid_set", {set_ht, set_ho, set_mt, set_mo, set_st, set_so}, 24'h0);
    check("rst_mid_fs", field_sel, 2'd0);
    check("rst_mid_ed", editing, 1'b0);
    check("rst_mid_blink", blink, 1'b0);
    check("rst_mid_commit", commit, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_commit", commit, 1'b0);
    rst_n = 1'b1;
    model_reset();
    tick(0, 0, 0);

    // Out-of-range snapshot 27 forces 00 on the first step.
    set_cur(24'h270000);
    tick(1, 0, 0);
    check("oor_snap", {set_ht, set_ho}, 8'h27);
    tick(0, 0, 1);
    check("oor_force", {set_ht, set_ho}, 8'h00);
    repeat (3) tick(1, 0, 0);
    tick(0, 0, 0);

    if (TMO_EN) begin
      // An untouched edit is abandoned after TO cycles with no commit.
      n = 0;
      tick(1, 0, 0);
      while (editing && n < 100) begin
        n++;
        tick(0, 0, 0);
      end
      check("timeout_cycles", n, TO);
      check("timeout_commit", commit, 1'b0);
    end

    // Randomized run against the reference model.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(9) == 0) begin
        set_cur(24'($urandom));
      end else begin
        set_cur({4'($urandom_range(2)), 4'($urandom_range(9)), 4'($urandom_range(5)),
                 4'($urandom_range(9)), 4'($urandom_range(5)), 4'($urandom_range(9))});
      end
      tick($urandom_range(7) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
